// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - xgriscv load/store unit, request/grant/rvalid data bus master
// Optional misaligned-access detection: define LSU_MISALIGN_CHECK_EN.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] memout,
  output logic        lsu_stall,
  output logic        misalign,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] memout_q, memout_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        access, is_byte, is_half, misalign_c;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign access  = mem_read | mem_write;
  assign is_byte = (funct3[1:0] == 2'b00);
  // funct3 011/110/111 fall through to word accesses
  assign is_half = (funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_c = access && (state_q == IDLE) &&
                      (is_byte ? 1'b0 : (is_half ? addr[0] : (addr[1:0] != 2'b00)));
`else
  assign misalign_c = 1'b0;
`endif

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = wdata;
    if (is_byte) begin
      store_be    = 4'b0001 << addr[1:0];
      store_wdata = {4{wdata[7:0]}};
    end else if (is_half) begin
      store_be    = addr[1] ? 4'b1100 : 4'b0011;
      store_wdata = {2{wdata[15:0]}};
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dbus_rdata[7:0];
      2'd1:    ld_byte = dbus_rdata[15:8];
      2'd2:    ld_byte = dbus_rdata[23:16];
      default: ld_byte = dbus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~funct3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~funct3_q[2]}}, ld_half};
      default: ld_data = dbus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    memout_d  = memout_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    lsu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misalign_c) begin
          lsu_stall = 1'b1;
          we_d      = mem_write;
          addr_d    = {addr[31:2], 2'b00};
          be_d      = mem_write ? store_be : 4'b1111;
          wdata_d   = store_wdata;
          funct3_d  = funct3;
          off_d     = addr[1:0];
          state_d   = REQ;
        end
      end
      REQ: begin
        lsu_stall = 1'b1;
        if (dbus_gnt) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        lsu_stall = 1'b1;
        if (dbus_rvalid) begin
          memout_d = ld_data;
          state_d  = DONE;
        end
      end
      // Unconditional return so the held instruction is never issued twice
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      memout_q <= 32'h0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'h0;
      off_q    <= 2'h0;
    end else begin
      state_q  <= state_d;
      memout_q <= memout_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
    end
  end

  assign memout     = memout_q;
  assign misalign   = misalign_c;
  assign dbus_req   = (state_q == REQ);
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  logic        clk, reset, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, memout, dbus_addr, dbus_wdata, dbus_rdata;
  logic        lsu_stall, misalign, dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [3:0]  dbus_be;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_mem;

  int          r_cyc, r_stall, r_txn, r_req;
  logic        r_mis, r_stable, r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata, r_addr, r_memout;

  load_store_unit dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .memout(memout),
    .lsu_stall(lsu_stall), .misalign(misalign), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus responder for one instruction; starts and ends at a negedge.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int gdly, input int rdly,
                            input logic stray);
    int   req_cnt, wait_cnt;
    logic granted, done;
    req_cnt = 0; wait_cnt = 0; granted = 1'b0; done = 1'b0;
    r_cyc = 0; r_stall = 0; r_txn = 0; r_req = 0; r_mis = 1'b0; r_stable = 1'b1;
    r_be = 4'h0; r_wdata = 32'h0; r_addr = 32'h0; r_we = 1'b0; r_memout = 32'h0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    while (!done) begin
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
      #1;
      if (misalign) r_mis = 1'b1;
      if (dbus_req) begin
        if (r_req == 0) begin
          r_be = dbus_be; r_wdata = dbus_wdata; r_addr = dbus_addr; r_we = dbus_we;
        end else if (dbus_be !== r_be || dbus_wdata !== r_wdata ||
                     dbus_addr !== r_addr || dbus_we !== r_we) begin
          r_stable = 1'b0;
        end
        r_req++;
        if (req_cnt == gdly) begin
          dbus_gnt = 1'b1;
          r_txn++;
        end else if (stray) begin
          dbus_rvalid = 1'b1;
        end
        req_cnt++;
      end else if (granted && !wr) begin
        if (wait_cnt == rdly) begin
          dbus_rvalid = 1'b1;
          dbus_rdata  = rdat;
        end
        wait_cnt++;
      end
      r_cyc++;
      if (lsu_stall) r_stall++;
      else begin
        done = 1'b1;
        r_memout = memout;
      end
      if (r_cyc >= 100) done = 1'b1;
      @(posedge clk);
      if (dbus_gnt) granted = 1'b1;
      @(negedge clk);
    end
    mem_read = 1'b0; mem_write = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = 32'h0;
    wdata = 32'h0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (memout !== 32'h0) begin n_fail++; $display("FAIL reset_memout: got %h want 0", memout); end
    n_checks++; if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", dbus_req); end
    n_checks++; if (dbus_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", dbus_we); end
    n_checks++; if (dbus_be !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %h want 0", dbus_be); end
    n_checks++; if (dbus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", dbus_addr); end
    n_checks++; if (dbus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", dbus_wdata); end
    n_checks++; if (lsu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", lsu_stall); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_mem = 32'h0;
  endtask

  task automatic test_lb_sign;
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b0);
    n_checks++; if (r_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL lb_addr: got %h want 00001000", r_addr); end
    n_checks++; if (r_memout !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_memout: got %h want ffffff80", r_memout); end
    n_checks++; if (r_stall !== 3) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d want 3", r_stall); end
    n_checks++; if (r_cyc !== 4) begin n_fail++; $display("FAIL lb_done_cycle: got %0d want 4", r_cyc); end
    n_checks++; if (r_be !== 4'hF || r_we !== 1'b0) begin n_fail++; $display("FAIL lb_be_we: got be %h we %b want be f we 0", r_be, r_we); end
    exp_mem = 32'hFFFF_FF80;
  endtask

  task automatic test_lhu_zero;
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 1, 1'b0);
    n_checks++; if (r_memout !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_memout: got %h want 00008001", r_memout); end
    n_checks++; if (r_cyc !== 6) begin n_fail++; $display("FAIL lhu_cycles: got %0d want 6", r_cyc); end
    exp_mem = 32'h0000_8001;
  endtask

  task automatic test_sb_lanes;
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'hAABB_CCDD, 32'h0, 3, 0, 1'b0);
    n_checks++; if (r_be !== 4'b0010) begin n_fail++; $display("FAIL sb_be: got %b want 0010", r_be); end
    n_checks++; if (r_wdata !== 32'hDDDD_DDDD) begin n_fail++; $display("FAIL sb_wdata: got %h want dddddddd", r_wdata); end
    n_checks++; if (r_stable !== 1'b1 || r_req !== 4) begin n_fail++; $display("FAIL sb_req_stable: got stable %b req %0d want 1 4", r_stable, r_req); end
    n_checks++; if (r_stall !== 5 || r_cyc !== 6) begin n_fail++; $display("FAIL sb_timing: got stall %0d cyc %0d want 5 6", r_stall, r_cyc); end
    n_checks++; if (r_memout !== exp_mem) begin n_fail++; $display("FAIL sb_memout: got %h want %h", r_memout, exp_mem); end
    n_checks++; if (r_we !== 1'b1 || r_txn !== 1) begin n_fail++; $display("FAIL sb_we_txn: got we %b txn %0d want 1 1", r_we, r_txn); end
  endtask

  task automatic test_misaligned_lw;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
    n_checks++; if (r_mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", r_mis); end
    n_checks++; if (r_req !== 0 || r_txn !== 0) begin n_fail++; $display("FAIL mis_no_req: got req %0d txn %0d want 0 0", r_req, r_txn); end
    n_checks++; if (r_stall !== 0 || r_cyc !== 1) begin n_fail++; $display("FAIL mis_stall: got stall %0d cyc %0d want 0 1", r_stall, r_cyc); end
    n_checks++; if (r_memout !== exp_mem) begin n_fail++; $display("FAIL mis_memout: got %h want %h", r_memout, exp_mem); end
`else
    n_checks++; if (r_mis !== 1'b0) begin n_fail++; $display("FAIL mis_flag: got %b want 0", r_mis); end
    n_checks++; if (r_addr !== 32'h0000_4000 || r_txn !== 1) begin n_fail++; $display("FAIL mis_issue: got addr %h txn %0d want 00004000 1", r_addr, r_txn); end
    n_checks++; if (r_memout !== 32'h1234_5678) begin n_fail++; $display("FAIL mis_memout: got %h want 12345678", r_memout); end
    exp_mem = 32'h1234_5678;
`endif
  endtask

  task automatic test_back_to_back;
    logic [31:0] ld_val, st_val;
    ld_val = $urandom; st_val = $urandom;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'h0, ld_val, 1, 2, 1'b0);
    n_checks++; if (r_txn !== 1 || r_req !== 2) begin n_fail++; $display("FAIL b2b_lw_txn: got txn %0d req %0d want 1 2", r_txn, r_req); end
    n_checks++; if (r_cyc !== 7 || r_memout !== ld_val) begin n_fail++; $display("FAIL b2b_lw: got cyc %0d memout %h want 7 %h", r_cyc, r_memout, ld_val); end
    exp_mem = ld_val;
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_5008, st_val, 32'h0, 2, 0, 1'b1);
    n_checks++; if (r_txn !== 1 || r_req !== 3) begin n_fail++; $display("FAIL b2b_sw_txn: got txn %0d req %0d want 1 3", r_txn, r_req); end
    n_checks++; if (r_cyc !== 5) begin n_fail++; $display("FAIL b2b_sw_cycles: got %0d want 5", r_cyc); end
    n_checks++; if (r_be !== 4'hF || r_wdata !== st_val || r_addr !== 32'h0000_5008) begin n_fail++; $display("FAIL b2b_sw_bus: got be %h wdata %h addr %h want f %h 00005008", r_be, r_wdata, r_addr, st_val); end
    n_checks++; if (r_memout !== exp_mem) begin n_fail++; $display("FAIL b2b_stray_rvalid: got memout %h want %h", r_memout, exp_mem); end
    #1;
    n_checks++; if (dbus_req !== 1'b0 || lsu_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_reissue: got req %b stall %b want 0 0", dbus_req, lsu_stall); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000; dbus_gnt = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (dbus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_req: got %b want 1", dbus_req); end
    reset = 1'b1;
    #1;
    n_checks++; if (dbus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_req: got %b want 0", dbus_req); end
    n_checks++; if (memout !== 32'h0) begin n_fail++; $display("FAIL rstmid_memout: got %h want 0", memout); end
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    #1;
    n_checks++; if (memout !== 32'h0 || lsu_stall !== 1'b0 || dbus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_rvalid: got memout %h stall %b req %b want 0 0 0", memout, lsu_stall, dbus_req); end
    @(negedge clk);
    exp_mem = 32'h0;
  endtask

  task automatic test_random;
    logic        rd, wr, mis;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat, m, v, ew;
    int          gd, rdl, sz, off, k, ecyc, be_i;
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 2);
      rd = (k != 1); wr = (k != 0);
      f3 = wr ? {1'b0, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 7));
      a = $urandom; wd = $urandom; rdat = $urandom;
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      sz = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
`ifdef LSU_MISALIGN_CHECK_EN
      mis = (sz == 2) ? a[0] : ((sz == 4) ? (a[1:0] != 2'b00) : 1'b0);
`else
      mis = 1'b0;
`endif
      off  = (sz == 1) ? int'(a % 4) : ((sz == 2) ? (a[1] ? 2 : 0) : 0);
      m    = (sz == 1) ? 32'hFF : ((sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF);
      v    = (rdat >> (8 * off)) & m;
      if (!f3[2] && sz < 4 && ((v >> (8 * sz - 1)) & 32'h1) == 32'h1) v = v | ~m;
      ew   = (sz == 1) ? wd[7:0] * 32'h0101_0101 : ((sz == 2) ? wd[15:0] * 32'h0001_0001 : wd);
      be_i = wr ? (((1 << sz) - 1) << off) : 15;
      ecyc = mis ? 1 : (wr ? 3 + gd : 4 + gd + rdl);
      if (!mis && !wr) exp_mem = v;
      run_access(rd, wr, f3, a, wd, rdat, gd, rdl, 1'b0);
      n_checks++; if (r_cyc !== ecyc) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d want %0d", i, r_cyc, ecyc); end
      n_checks++; if (r_stall !== (mis ? 0 : ecyc - 1)) begin n_fail++; $display("FAIL rnd%0d_stall: got %0d want %0d", i, r_stall, mis ? 0 : ecyc - 1); end
      n_checks++; if (r_txn !== (mis ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_txn: got %0d want %0d", i, r_txn, mis ? 0 : 1); end
      n_checks++; if (r_mis !== mis) begin n_fail++; $display("FAIL rnd%0d_misalign: got %b want %b", i, r_mis, mis); end
      n_checks++; if (r_memout !== exp_mem) begin n_fail++; $display("FAIL rnd%0d_memout: got %h want %h", i, r_memout, exp_mem); end
      if (!mis) begin
        n_checks++; if (r_addr !== (a & 32'hFFFF_FFFC) || r_we !== wr) begin n_fail++; $display("FAIL rnd%0d_addr_we: got %h %b want %h %b", i, r_addr, r_we, a & 32'hFFFF_FFFC, wr); end
        n_checks++; if (r_be !== be_i[3:0] || r_stable !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_be: got %b stable %b want %b 1", i, r_be, r_stable, be_i[3:0]); end
        if (wr) begin
          n_checks++; if (r_wdata !== ew) begin n_fail++; $display("FAIL rnd%0d_wdata: got %h want %h", i, r_wdata, ew); end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_lb_sign;
    test_lhu_zero;
    test_sb_lanes;
    test_misaligned_lw;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
